vga_image_writer: RTL and testbench

- Producer side of the 32-bit `image_word` framebuffer write bus consumed by the VGA block.
- Accepts pixel-write and span-fill commands from the processor MMIO path over a valid/ready handshake, and buffers them in a small command FIFO.
- Serialises the commands into single-cycle image RAM write strobes, with a configurable idle gap so scan-out reads are not starved.

---
 rtl/vga_image_writer.sv | 113 +++++++++++
 tb/tb_vga_image_writer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vga_image_writer.sv
// Command FIFO plus write engine that turns pixel/span commands into single-cycle
// image RAM write strobes on the image_word bus, with an optional idle gap after each write.
module vga_image_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int WRITE_GAP  = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [14:0] cmd_addr,
  input  logic [14:0] cmd_len,
  input  logic [7:0]  cmd_color,
  output logic [31:0] image_word,
  output logic        busy,
  output logic        done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [14:0] addr;
    logic [14:0] rem;
    logic [7:0]  color;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  cmd_t           mem_q [FIFO_DEPTH];
  cmd_t           head;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  state_t         state_q;
  logic [14:0]    addr_q, rem_q;
  logic [7:0]     color_q;
  logic [3:0]     gcnt_q;
  logic [31:0]    word_q;
  logic           busy_q, done_q;
  logic           push, pop;

  assign cmd_ready  = (count_q != CW'(FIFO_DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign pop        = (state_q == IDLE) && (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign image_word = word_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // The pixel count is resolved at push time so the engine only sees "remaining".
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: cmd_addr, rem: (cmd_op ? cmd_len : 15'd1), color: cmd_color};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      color_q  <= '0;
      gcnt_q   <= '0;
      word_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      busy_q <= (count_q != '0) || (state_q != IDLE);
      done_q <= 1'b0;
      word_q <= '0;

      case (state_q)
        IDLE: begin
          if (pop) begin
            addr_q  <= head.addr;
            rem_q   <= head.rem;
            color_q <= head.color;
            if (head.rem == '0) done_q  <= 1'b1;
            else                state_q <= WRITE;
          end
        end
        WRITE: begin
          word_q <= {8'h00, 1'b1, color_q, addr_q};
          addr_q <= addr_q + 15'd1;
          rem_q  <= rem_q - 15'd1;
          if (rem_q == 15'd1) done_q <= 1'b1;
          if (WRITE_GAP != 0) begin
            state_q <= GAP;
            gcnt_q  <= 4'(WRITE_GAP - 1);
          end else if (rem_q == 15'd1) begin
            state_q <= IDLE;
          end
        end
        GAP: begin
          if (gcnt_q == '0) state_q <= (rem_q != '0) ? WRITE : IDLE;
          else              gcnt_q  <= gcnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_image_writer.sv
// Directed bench: dut0 runs with no write gap, dut2 with a two-cycle gap.
module tb_vga_image_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid0, cmd_valid2;
  logic        cmd_op;
  logic [14:0] cmd_addr, cmd_len;
  logic [7:0]  cmd_color;
  logic        ready0, ready2, busy0, busy2, done0, done2;
  logic [31:0] word0, word2;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [31:0] wr_q[$];

  always #5 clk = ~clk;

  vga_image_writer #(.FIFO_DEPTH(4), .WRITE_GAP(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid0), .cmd_ready(ready0),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_color(cmd_color),
    .image_word(word0), .busy(busy0), .done(done0));

  vga_image_writer #(.FIFO_DEPTH(4), .WRITE_GAP(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid2), .cmd_ready(ready2),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_color(cmd_color),
    .image_word(word2), .busy(busy2), .done(done2));

  // Record every dut0 write and done pulse.
  always @(posedge clk) begin
    #1;
    if (word0[23]) wr_q.push_back(word0);
    if (done0) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Push one command; returns at edge T + 1ns.
  task automatic push(input bit d2, input logic op, input logic [14:0] addr,
                      input logic [14:0] len, input logic [7:0] color);
    @(negedge clk);
    cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_color = color;
    if (d2) cmd_valid2 = 1'b1; else cmd_valid0 = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid0 = 1'b0; cmd_valid2 = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy0 || busy2) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) chk(tag, 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp6 [6];
    int waited;
    exp6[0] = 32'h00880200; exp6[1] = 32'h00888201; exp6[2] = 32'h00890202;
    exp6[3] = 32'h00898203; exp6[4] = 32'h008A0204; exp6[5] = 32'h008A8205;

    reset_n = 1'b0; cmd_valid0 = 1'b0; cmd_valid2 = 1'b0;
    cmd_op = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_color = '0;
    repeat (3) @(negedge clk);
    chk("rst_word", word0, 32'h0);
    chk("rst_ready", {31'd0, ready0}, 32'd1);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    reset_n = 1'b1;

    // Single pixel write
    push(0, 1'b0, 15'h0123, 15'd9, 8'h5A);
    step(1); chk("px_t1", word0, 32'h0);
    step(1); chk("px_t2", word0, 32'h00AD0123);
    chk("px_done", {31'd0, done0}, 32'd1);
    chk("px_busy_t2", {31'd0, busy0}, 32'd1);
    step(1); chk("px_t3", word0, 32'h0);
    chk("px_busy_t3", {31'd0, busy0}, 32'd0);
    chk("px_done_t3", {31'd0, done0}, 32'd0);
    wait_idle("px_idle", 50);

    // Fill len=3, no gap
    push(0, 1'b1, 15'h0010, 15'd3, 8'h07);
    step(2); chk("f0_w0", word0, 32'h00838010);
    chk("f0_done0", {31'd0, done0}, 32'd0);
    step(1); chk("f0_w1", word0, 32'h00838011);
    step(1); chk("f0_w2", word0, 32'h00838012);
    chk("f0_done2", {31'd0, done0}, 32'd1);
    step(1); chk("f0_end", word0, 32'h0);
    wait_idle("f0_idle", 50);

    // Fill len=3, gap 2
    push(1, 1'b1, 15'h0010, 15'd3, 8'h07);
    step(2); chk("g2_w0", word2, 32'h00838010);
    step(1); chk("g2_gap3", word2, 32'h0);
    step(1); chk("g2_gap4", word2, 32'h0);
    step(1); chk("g2_w1", word2, 32'h00838011);
    step(3); chk("g2_w2", word2, 32'h00838012);
    chk("g2_done", {31'd0, done2}, 32'd1);
    step(2); chk("g2_busy10", {31'd0, busy2}, 32'd1);
    step(1); chk("g2_busy11", {31'd0, busy2}, 32'd0);
    wait_idle("g2_idle", 50);

    // Address wrap
    push(0, 1'b1, 15'h7FFE, 15'd3, 8'h00);
    step(2); chk("wrap0", word0, 32'h00807FFE);
    step(1); chk("wrap1", word0, 32'h00807FFF);
    step(1); chk("wrap2", word0, 32'h00800000);
    wait_idle("wrap_idle", 50);

    // Backpressure: long fill, then six queued single writes with valid held
    wr_q.delete(); done_cnt = 0;
    push(0, 1'b1, 15'h0100, 15'd100, 8'h01);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmd_op = 1'b0; cmd_addr = 15'h0200 + 15'(i); cmd_len = '0; cmd_color = 8'h10 + 8'(i);
      cmd_valid0 = 1'b1;
      waited = 0;
      while (!ready0 && waited < 400) begin
        @(negedge clk);
        waited++;
      end
      if (i < 4) chk($sformatf("bp_nowait%0d", i), waited, 32'd0);
      if (i == 4) chk("bp_stall4", {31'd0, waited > 0}, 32'd1);
      @(posedge clk);
      #1;
    end
    @(negedge clk); cmd_valid0 = 1'b0;
    wait_idle("bp_idle", 400);
    chk("bp_done_cnt", done_cnt, 32'd7);
    chk("bp_wr_cnt", wr_q.size(), 32'd106);
    if (wr_q.size() == 106) begin
      chk("bp_fill_first", wr_q[0], 32'h00808100);
      chk("bp_fill_last", wr_q[99], 32'h00808163);
      for (int i = 0; i < 6; i++) chk($sformatf("bp_cmd%0d", i), wr_q[100 + i], exp6[i]);
    end

    // Zero-length fill
    wr_q.delete(); done_cnt = 0;
    push(0, 1'b1, 15'h0400, 15'd0, 8'hFF);
    step(1); chk("z_done1", {31'd0, done0}, 32'd1);
    chk("z_word1", word0, 32'h0);
    step(1); chk("z_done2", {31'd0, done0}, 32'd0);
    wait_idle("z_idle", 50);
    chk("z_wr_cnt", wr_q.size(), 32'd0);
    chk("z_done_cnt", done_cnt, 32'd1);

    // Asynchronous reset mid-fill
    push(0, 1'b1, 15'h0300, 15'd50, 8'h03);
    step(10); chk("rmid_active", {31'd0, word0[23]}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rmid_word", word0, 32'h0);
    chk("rmid_ready", {31'd0, ready0}, 32'd1);
    chk("rmid_busy", {31'd0, busy0}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    wr_q.delete(); done_cnt = 0;
    step(60);
    chk("rmid_no_wr", wr_q.size(), 32'd0);
    chk("rmid_no_done", done_cnt, 32'd0);
    chk("rmid_busy_after", {31'd0, busy0}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
